// File: rtl/spike_weight_accumulator.sv
// Per-time-step saturating accumulation of synaptic weights gated by presynaptic spike trains.
// A completed current set is held for the LIF stage until acknowledged.
module spike_weight_accumulator #(
    parameter int unsigned T = 16,
    parameter int unsigned Q = 10,
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_weight,
    input  logic [T-1:0]     in_spikes,
    input  logic             in_last,
    output logic             out_val,
    output logic [Q-1:0]     out_data [T-1:0],
    input  logic             out_ack,
    output logic             out_sat,
    output logic [7:0]       beat_cnt
);

    localparam int unsigned SUM_W = Q + 1;
    localparam logic [Q-1:0] ACC_MAX = '1;
    localparam logic [7:0]   CNT_MAX = 8'hFF;

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    state_t           state;
    logic [Q-1:0]     acc      [T-1:0];
    logic [Q-1:0]     acc_next [T-1:0];
    logic [SUM_W-1:0] sum_wide [T-1:0];
    logic             sat_beat;
    logic             accept;

    assign accept   = in_valid && in_ready;
    assign out_data = acc;

    // Candidate per-step sums, widened one bit so overflow clamps to full scale
    always_comb begin
        sat_beat = 1'b0;
        for (int t = 0; t < int'(T); t++) begin
            sum_wide[t] = {1'b0, acc[t]} + (in_spikes[t] ? SUM_W'(in_weight) : '0);
            acc_next[t] = sum_wide[t][Q-1:0];
            if (sum_wide[t][Q]) begin
                acc_next[t] = ACC_MAX;
                sat_beat    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACC;
            in_ready <= 1'b1;
            out_val  <= 1'b0;
            out_sat  <= 1'b0;
            beat_cnt <= '0;
            for (int t = 0; t < int'(T); t++) acc[t] <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        acc      <= acc_next;
                        out_sat  <= out_sat | sat_beat;
                        beat_cnt <= (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + 8'd1;
                        if (in_last) begin
                            state    <= ST_HOLD;
                            in_ready <= 1'b0;
                            out_val  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ack) begin
                        state    <= ST_ACC;
                        in_ready <= 1'b1;
                        out_val  <= 1'b0;
                        out_sat  <= 1'b0;
                        beat_cnt <= '0;
                        for (int t = 0; t < int'(T); t++) acc[t] <= '0;
                    end
                end
                default: begin
                    state    <= ST_ACC;
                    in_ready <= 1'b1;
                    out_val  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_weight_accumulator.sv
// Directed bench for spike_weight_accumulator with hand-computed expected currents.
module tb_spike_weight_accumulator;

    localparam int unsigned T = 16;
    localparam int unsigned Q = 10;
    localparam int unsigned W = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_weight;
    logic [T-1:0]  in_spikes;
    logic          in_last;
    logic          out_val;
    logic [Q-1:0]  out_data [T-1:0];
    logic          out_ack;
    logic          out_sat;
    logic [7:0]    beat_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [Q-1:0] exp_data [16];

    spike_weight_accumulator #(.T(T), .Q(Q), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_spikes (in_spikes),
        .in_last   (in_last),
        .out_val   (out_val),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .out_sat   (out_sat),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_exp(input logic [Q-1:0] v);
        for (int i = 0; i < 16; i++) exp_data[i] = v;
    endtask

    task automatic check_data(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(out_data[i]), 32'(exp_data[i]));
    endtask

    task automatic send_beat(input string tag, input logic [W-1:0] w, input logic [T-1:0] s,
                             input logic l);
        in_valid  = 1'b1;
        in_weight = w;
        in_spikes = s;
        in_last   = l;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_set(input string tag);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check({tag, "_rel_val"}, 32'(out_val), 32'd0);
        check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rel_cnt"}, 32'(beat_cnt), 32'd0);
        check({tag, "_rel_sat"}, 32'(out_sat), 32'd0);
        fill_exp('0);
        check_data({tag, "_rel_data"});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_weight = '0; in_spikes = '0;
        in_last = 1'b0; out_ack = 1'b0;
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_val", 32'(out_val), 32'd0);
        check("rst_sat", 32'(out_sat), 32'd0);
        check("rst_cnt", 32'(beat_cnt), 32'd0);
        fill_exp('0);
        check_data("rst_data");
        rst = 1'b0;
        step();

        // single-beat set
        send_beat("t1", 8'd5, 16'h0001, 1'b1);
        check("t1_val", 32'(out_val), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd0);
        check("t1_cnt", 32'(beat_cnt), 32'd1);
        check("t1_sat", 32'(out_sat), 32'd0);
        fill_exp('0); exp_data[0] = 10'd5;
        check_data("t1_data");
        release_set("t1");

        // three back-to-back beats
        send_beat("t2a", 8'd3, 16'hFFFF, 1'b0);
        send_beat("t2b", 8'd4, 16'h00FF, 1'b0);
        send_beat("t2c", 8'd7, 16'h8000, 1'b1);
        check("t2_val", 32'(out_val), 32'd1);
        check("t2_cnt", 32'(beat_cnt), 32'd3);
        fill_exp(10'd3);
        for (int i = 0; i < 8; i++) exp_data[i] = 10'd7;
        exp_data[15] = 10'd10;
        check_data("t2_data");
        release_set("t2");

        // saturation at 2^Q-1
        for (int i = 0; i < 4; i++) send_beat("t3", 8'd255, 16'h0002, 1'b0);
        check("t3_pre_sat", 32'(out_sat), 32'd0);
        check("t3_pre_acc", 32'(out_data[1]), 32'd1020);
        send_beat("t3_last", 8'd255, 16'h0002, 1'b1);
        check("t3_sat", 32'(out_sat), 32'd1);
        check("t3_cnt", 32'(beat_cnt), 32'd5);
        fill_exp('0); exp_data[1] = 10'd1023;
        check_data("t3_data");
        release_set("t3");

        // backpressure in HOLD
        send_beat("t4", 8'd2, 16'h000F, 1'b1);
        in_valid = 1'b1; in_weight = 8'd9; in_spikes = 16'h00F0; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_bp_ready%0d", i), 32'(in_ready), 32'd0);
            step();
            check($sformatf("t4_bp_d0_%0d", i), 32'(out_data[0]), 32'd2);
            check($sformatf("t4_bp_d4_%0d", i), 32'(out_data[4]), 32'd0);
            check($sformatf("t4_bp_cnt%0d", i), 32'(beat_cnt), 32'd1);
        end
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("t4_ack_ready", 32'(in_ready), 32'd1);
        fill_exp('0);
        check_data("t4_cleared");
        step();
        in_valid = 1'b0;
        check("t4_held_cnt", 32'(beat_cnt), 32'd1);
        check("t4_held_val", 32'(out_val), 32'd0);
        for (int i = 4; i < 8; i++) exp_data[i] = 10'd9;
        check_data("t4_held");
        send_beat("t4_end", 8'd0, 16'h0000, 1'b1);
        check("t4_end_cnt", 32'(beat_cnt), 32'd2);
        check("t4_end_val", 32'(out_val), 32'd1);
        check_data("t4_end");
        release_set("t4");

        // asynchronous reset mid-set discards partial sums
        send_beat("t5a", 8'd6, 16'hFFFF, 1'b0);
        send_beat("t5b", 8'd6, 16'hFFFF, 1'b0);
        check("t5_partial", 32'(out_data[9]), 32'd12);
        rst = 1'b1;
        #1;
        check("t5_async_cnt", 32'(beat_cnt), 32'd0);
        check("t5_async_d9", 32'(out_data[9]), 32'd0);
        step();
        rst = 1'b0;
        send_beat("t5c", 8'd1, 16'hFFFF, 1'b1);
        check("t5_cnt", 32'(beat_cnt), 32'd1);
        check("t5_val", 32'(out_val), 32'd1);
        fill_exp(10'd1);
        check_data("t5_data");
        // reset while holding
        rst = 1'b1;
        #1;
        check("t5_hold_rst_val", 32'(out_val), 32'd0);
        check("t5_hold_rst_ready", 32'(in_ready), 32'd1);
        check("t5_hold_rst_d0", 32'(out_data[0]), 32'd0);
        step();
        rst = 1'b0;

        // stray out_ack during ACC while beats stream
        out_ack = 1'b1;
        send_beat("t6a", 8'd1, 16'h0003, 1'b0);
        send_beat("t6b", 8'd2, 16'h0006, 1'b0);
        send_beat("t6c", 8'd3, 16'h000C, 1'b0);
        out_ack = 1'b0;
        send_beat("t6d", 8'd4, 16'h0001, 1'b1);
        check("t6_val", 32'(out_val), 32'd1);
        check("t6_cnt", 32'(beat_cnt), 32'd4);
        fill_exp('0);
        exp_data[0] = 10'd5; exp_data[1] = 10'd3; exp_data[2] = 10'd5; exp_data[3] = 10'd3;
        check_data("t6_data");
        // ack held three cycles releases once, then idles in ACC
        out_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_ack_val%0d", i), 32'(out_val), 32'd0);
            check($sformatf("t6_ack_ready%0d", i), 32'(in_ready), 32'd1);
            check($sformatf("t6_ack_cnt%0d", i), 32'(beat_cnt), 32'd0);
        end
        out_ack = 1'b0;

        // beat counter saturates at 255; zero-weight beats still count
        for (int i = 0; i < 259; i++) send_beat("t7", 8'd0, 16'hFFFF, 1'b0);
        check("t7_cnt_pre", 32'(beat_cnt), 32'd255);
        send_beat("t7_last", 8'd0, 16'h0000, 1'b1);
        check("t7_cnt", 32'(beat_cnt), 32'd255);
        check("t7_val", 32'(out_val), 32'd1);
        check("t7_sat", 32'(out_sat), 32'd0);
        check("t7_d0", 32'(out_data[0]), 32'd0);
        release_set("t7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
